// File: rtl/dpsk_bit_sync_if.sv
// Bus between the Costas demodulator front end and the bit synchroniser.
//
// Handshake: there is no backpressure. din is qualified by din_ce (one clk
// wide, may be high on consecutive clks). bit_out is qualified by bit_valid,
// byte_out by byte_valid; bit_valid, byte_valid and frame_start are one-clk
// pulses that the sink must accept in the clk they are high. locked is a
// level. fsm_state mirrors the frame FSM (0 = HUNT, 1 = PAYLOAD) for debug.
interface dpsk_bit_sync_if;
    logic       din_ce;
    logic       din;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       locked;
    logic       fsm_state;

    modport master (
        output din_ce, din,
        input  bit_out, bit_valid, byte_out, byte_valid, frame_start, locked,
               fsm_state
    );

    modport slave (
        input  din_ce, din,
        output bit_out, bit_valid, byte_out, byte_valid, frame_start, locked,
               fsm_state
    );
endinterface

// File: rtl/dpsk_bit_sync.sv
// DPSK symbol timing recovery, differential decoder and frame extractor.
// An early/late phase counter is nudged by data transitions so that symbol
// boundaries land at ph=0 and decisions are taken mid-symbol (ph=SPS/2).
// Decoded bits are searched for SYNC_WORD; the following FRAME_BYTES bytes
// are delivered MSB first.
module dpsk_bit_sync #(
    parameter int          SPS         = 16,
    parameter logic [15:0] SYNC_WORD   = 16'hEB90,
    parameter int          FRAME_BYTES = 32,
    parameter int          LOCK_SYMS   = 8
) (
    input logic           clk,
    input logic           rst,
    dpsk_bit_sync_if.slave bus
);

    localparam int PW = $clog2(SPS);
    localparam int LW = $clog2(LOCK_SYMS + 1);

    localparam logic [PW:0]   SPS_W    = (PW + 1)'(SPS);
    localparam logic [PW-1:0] PH_HALF  = PW'(SPS / 2);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_SYMS);
    localparam logic [7:0]    LAST_BYTE = 8'(FRAME_BYTES - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Timing recovery state
    logic [PW-1:0] ph;
    logic          prev_din;
    logic          prev_sym;
    logic          corr_done;       // a correction was already made this period
    logic          corr_since_dec;  // a correction happened since the last decision
    logic [LW-1:0] lock_cnt;

    // Frame extraction state
    state_t        state;
    state_t        state_nxt;
    logic [15:0]   sync_sr;
    logic [6:0]    byte_sr;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_cnt;

    // Registered outputs
    logic          bit_out_r;
    logic          bit_valid_r;
    logic [7:0]    byte_out_r;
    logic          byte_valid_r;
    logic          frame_start_r;

    // Per-strobe combinational decisions
    logic          transition;
    logic          do_corr;
    logic          do_retard;
    logic          do_advance;
    logic          decide;
    logic          dec_bit;
    logic [PW:0]   ph_sum;
    logic [PW-1:0] ph_nxt;
    logic          wrap;

    // Frame FSM combinational results
    logic          sync_hit;
    logic          byte_done;
    logic          frame_done;
    logic [15:0]   sync_shift;
    logic [7:0]    byte_full;

    // Classify the current strobe: transition, correction kind, decision,
    // and the phase value that follows it (hold, +1 or +2 modulo SPS).
    always_comb begin
        transition = 1'b0;
        do_corr    = 1'b0;
        do_retard  = 1'b0;
        do_advance = 1'b0;
        decide     = 1'b0;
        dec_bit    = bus.din ^ prev_sym;
        ph_sum     = '0;
        ph_nxt     = ph;
        wrap       = 1'b0;

        if (bus.din_ce) begin
            transition = (bus.din != prev_din);
            do_corr    = transition && (ph != '0) && !corr_done;
            do_retard  = do_corr && (ph < PH_HALF);
            do_advance = do_corr && (ph >= PH_HALF);
            decide     = (ph == PH_HALF);

            if (do_retard) begin
                ph_nxt = ph;
            end else begin
                ph_sum = {1'b0, ph} + (do_advance ? (PW + 1)'(2) : (PW + 1)'(1));
                if (ph_sum >= SPS_W) begin
                    ph_nxt = PW'(ph_sum - SPS_W);
                    wrap   = 1'b1;
                end else begin
                    ph_nxt = ph_sum[PW-1:0];
                end
            end
        end
    end

    // Phase tracking, correction bookkeeping and lock counting on each strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph             <= '0;
            prev_din       <= 1'b0;
            corr_done      <= 1'b0;
            corr_since_dec <= 1'b0;
            lock_cnt       <= '0;
        end else if (bus.din_ce) begin
            ph       <= ph_nxt;
            prev_din <= bus.din;

            // A wrap opens a fresh symbol period, even when an advance caused it.
            if (wrap) begin
                corr_done <= 1'b0;
            end else if (do_corr) begin
                corr_done <= 1'b1;
            end

            if (decide) begin
                corr_since_dec <= 1'b0;
            end else if (do_corr) begin
                corr_since_dec <= 1'b1;
            end

            if (do_corr) begin
                lock_cnt <= '0;
            end else if (decide && !corr_since_dec && (lock_cnt != LOCK_MAX)) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    // Symbol decision and differential decode, presented the clk after the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_sym    <= 1'b0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
        end else begin
            bit_valid_r <= decide;
            if (decide) begin
                bit_out_r <= dec_bit;
                prev_sym  <= bus.din;
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state: hunt for the sync word, then count payload bytes.
    always_comb begin
        state_nxt  = state;
        sync_hit   = 1'b0;
        byte_done  = 1'b0;
        frame_done = 1'b0;
        sync_shift = {sync_sr[14:0], dec_bit};
        byte_full  = {byte_sr, dec_bit};

        case (state)
            HUNT: begin
                if (decide && (sync_shift == SYNC_WORD)) begin
                    sync_hit  = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (decide && (bit_cnt == 3'd7)) begin
                    byte_done = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        frame_done = 1'b1;
                        state_nxt  = HUNT;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Frame datapath: sync shifter in HUNT, byte assembly and counting in PAYLOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_sr       <= '0;
            byte_sr       <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            byte_out_r    <= '0;
            byte_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= sync_hit;
            byte_valid_r  <= byte_done;

            if ((state == HUNT) && decide) begin
                sync_sr <= sync_shift;
            end

            if (sync_hit) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end

            if ((state == PAYLOAD) && decide) begin
                byte_sr <= byte_full[6:0];
                bit_cnt <= bit_cnt + 1'b1;
                if (byte_done) begin
                    byte_out_r <= byte_full;
                    byte_cnt   <= byte_cnt + 1'b1;
                end
            end

            // Leave the shifter empty so a stale tail cannot complete a match.
            if (frame_done) begin
                sync_sr <= '0;
            end
        end
    end

    assign bus.bit_out     = bit_out_r;
    assign bus.bit_valid   = bit_valid_r;
    assign bus.byte_out    = byte_out_r;
    assign bus.byte_valid  = byte_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.locked      = (lock_cnt == LOCK_MAX);
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_dpsk_bit_sync.sv
// Directed bench for dpsk_bit_sync at SPS=16, sync 0xEB90, 32-byte frames.
module tb_dpsk_bit_sync;

    localparam int SPS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Monitor accumulators (written only by the monitor)
    int n_bits = 0, n_ones = 0, n_fs = 0, fs_at = 0, n_orphan = 0;
    int n_rise = 0, rise_at = 0, cyc = 0, last_bv = -1, bv_gap = 0;
    logic lock_prev = 1'b0;
    logic [7:0] got_q[$];

    // Baselines for the current step
    int b_bits, b_ones, b_fs, b_bytes, b_rise, b_orphan;

    logic [7:0] exp_q[$];
    logic       enc_sym;
    int         ce_gap;

    dpsk_bit_sync_if bus();

    dpsk_bit_sync #(
        .SPS(SPS), .SYNC_WORD(16'hEB90), .FRAME_BYTES(32), .LOCK_SYMS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor: sample outputs on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (bus.bit_valid) begin
            n_bits++;
            if (bus.bit_out) n_ones++;
            if (last_bv >= 0) bv_gap = cyc - last_bv;
            last_bv = cyc;
        end
        if (bus.locked && !lock_prev) begin
            n_rise++;
            rise_at = n_bits;
        end
        lock_prev = bus.locked;
        if (bus.frame_start) begin
            n_fs++;
            fs_at = n_bits;
        end
        if (bus.byte_valid) got_q.push_back(bus.byte_out);
        if ((bus.frame_start || bus.byte_valid) && !bus.bit_valid) n_orphan++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_bits   = n_bits;
        b_ones   = n_ones;
        b_fs     = n_fs;
        b_bytes  = got_q.size();
        b_rise   = n_rise;
        b_orphan = n_orphan;
        last_bv  = -1;
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.din_ce = 1'b0;
        bus.din    = 1'b0;
        tick(3);
        rst     = 1'b1;
        enc_sym = 1'b0;
        mark();
    endtask

    task automatic strobe(input logic d);
        bus.din_ce = 1'b1;
        bus.din    = d;
        tick(1);
        bus.din_ce = 1'b0;
        if (ce_gap > 1) tick(ce_gap - 1);
    endtask

    task automatic send_sym(input logic s);
        for (int i = 0; i < SPS; i++) strobe(s);
    endtask

    task automatic send_bit(input logic b);
        enc_sym = enc_sym ^ b;
        send_sym(enc_sym);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_count"}, got_q.size() - b_bytes, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b_bytes + i < got_q.size())
                chk($sformatf("%s_byte%0d", tag, i), got_q[b_bytes + i], exp_q[i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_bit_valid"}, bus.bit_valid, 0);
        chk({tag, "_bit_out"}, bus.bit_out, 0);
        chk({tag, "_byte_valid"}, bus.byte_valid, 0);
        chk({tag, "_byte_out"}, bus.byte_out, 0);
        chk({tag, "_frame_start"}, bus.frame_start, 0);
        chk({tag, "_locked"}, bus.locked, 0);
        chk({tag, "_fsm"}, bus.fsm_state, 0);
    endtask

    initial begin
        ce_gap     = 1;
        enc_sym    = 1'b0;
        bus.din_ce = 1'b0;
        bus.din    = 1'b0;

        // Reset state, with strobes toggling while held
        tick(2);
        for (int i = 0; i < 4; i++) strobe(i[0]);
        @(negedge clk);
        check_idle_outputs("reset");

        // Constant zero input, 200 back-to-back strobes
        do_reset();
        for (int i = 0; i < 200; i++) strobe(1'b0);
        tick(4);
        chk("const_bits", n_bits - b_bits, 12);
        chk("const_ones", n_ones - b_ones, 0);
        chk("const_lock_rise_at", rise_at - b_bits, 8);
        chk("const_locked", bus.locked, 1);
        chk("const_gap", bv_gap, 16);
        chk("const_no_fs", n_fs - b_fs, 0);

        // Alternating symbols, first transition at ph=5 (retard path)
        do_reset();
        for (int i = 0; i < 5; i++) strobe(1'b0);
        for (int k = 0; k < 16; k++) send_sym(~k[0]);
        tick(4);
        chk("retard_bits", n_bits - b_bits, 16);
        chk("retard_ones", n_ones - b_ones, 16);
        chk("retard_rises", n_rise - b_rise, 1);
        chk("retard_lock_at", rise_at - b_bits, 13);
        chk("retard_locked", bus.locked, 1);

        // Alternating symbols, first transition at ph=12 (advance path)
        do_reset();
        for (int i = 0; i < 12; i++) strobe(1'b0);
        for (int k = 0; k < 16; k++) send_sym(~k[0]);
        tick(4);
        chk("advance_bits", n_bits - b_bits, 17);
        chk("advance_ones", n_ones - b_ones, 16);
        chk("advance_rises", n_rise - b_rise, 1);
        chk("advance_lock_at", rise_at - b_bits, 13);

        // Full frame: sync word then 0x00..0x1F
        do_reset();
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        tick(4);
        chk("frame_fs", n_fs - b_fs, 1);
        chk("frame_fs_at", fs_at - b_bits, 16);
        check_bytes("frame");
        chk("frame_bits", n_bits - b_bits, 272);
        chk("frame_aligned", n_orphan - b_orphan, 0);
        chk("frame_hunt", bus.fsm_state, 0);
        chk("frame_locked", bus.locked, 1);

        // Payload carrying the sync word; then a new sync re-arms the frame
        do_reset();
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] v;
            v = (i == 4) ? 8'hEB : (i == 5) ? 8'h90 : 8'(8'h40 + i);
            send_byte(v);
            exp_q.push_back(v);
        end
        tick(4);
        chk("embed_fs", n_fs - b_fs, 1);
        check_bytes("embed");
        send_byte(8'hEB);
        send_byte(8'h90);
        tick(4);
        chk("embed_refs", n_fs - b_fs, 2);
        chk("embed_refs_at", fs_at - b_bits, 288);
        chk("embed_payload_state", bus.fsm_state, 1);

        // Reset in the middle of a frame
        do_reset();
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 0; i < 11; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        tick(2);
        check_bytes("midrst_pre");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) strobe(i[0]);
        @(negedge clk);
        check_idle_outputs("midrst_hold");
        tick(1);
        rst     = 1'b1;
        enc_sym = 1'b0;
        mark();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
        tick(4);
        chk("midrst_bytes", got_q.size() - b_bytes, 0);
        chk("midrst_fs", n_fs - b_fs, 0);
        chk("midrst_bits", n_bits - b_bits, 40);
        chk("midrst_hunt", bus.fsm_state, 0);

        // Sparse strobes: din_ce every third clk
        ce_gap = 3;
        do_reset();
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        tick(8);
        chk("sparse_fs", n_fs - b_fs, 1);
        check_bytes("sparse");
        chk("sparse_gap", bv_gap, 48);
        chk("sparse_hunt", bus.fsm_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
